// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL configuration sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHoldRst,
    StWaitLock,
    StQualify,
    StLocked,
    StFail
  } seq_state_e;

  localparam int unsigned DefResetHold   = 16;
  localparam int unsigned DefLockTimeout = 65536;
  localparam int unsigned DefStableCycles = 256;
  localparam int unsigned DefMaxRetries  = 3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_cfg_sequencer.sv
// Brings a PLL out of reset, qualifies lock, relocks warm on lock loss and
// retries cold on timeout. Single sys_clk domain, all outputs registered.
module pll_cfg_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD    = DefResetHold,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned MAX_RETRIES   = DefMaxRetries
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_div_val,
  input  logic [31:0] cfg_initial_freq,
  output logic        pll_rst_n,
  output logic [31:0] pll_div_val,
  output logic [31:0] pll_initial_freq,
  input  logic        pll_lock_detect,
  input  logic [31:0] pll_dco_word,
  output logic        locked,
  output logic        busy,
  output logic        error,
  output logic        lock_lost,
  output logic [2:0]  retry_count,
  output logic [31:0] locked_dco_word
);

  // The attempt timer also paces the reset hold, so it must cover both.
  localparam int unsigned TimerMax = (LOCK_TIMEOUT > RESET_HOLD) ? LOCK_TIMEOUT : RESET_HOLD;
  localparam int unsigned TimerW   = cnt_width(TimerMax);
  localparam int unsigned StableW  = cnt_width(STABLE_CYCLES);

  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0]  HoldLast    = TimerW'(RESET_HOLD - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(STABLE_CYCLES - 1);
  localparam logic [2:0]         RetryMax    = 3'(MAX_RETRIES);

  seq_state_e         state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d, timer_inc;
  logic [StableW-1:0] stable_q, stable_d, stable_inc;
  logic [2:0]         retry_q, retry_d;
  logic [31:0]        cfg_freq_q, cfg_freq_d;
  logic [31:0]        pll_div_q, pll_div_d;
  logic [31:0]        pll_freq_q, pll_freq_d;
  logic [31:0]        dco_q, dco_d;
  logic               lock_lost_q, lock_lost_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               pll_rst_n_q, pll_rst_n_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic               xfer, expire;

  assign xfer       = cfg_valid & cfg_ready_q;
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign stable_inc = (stable_q == '1) ? stable_q : stable_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stable_d    = stable_q;
    retry_d     = retry_q;
    cfg_freq_d  = cfg_freq_q;
    pll_div_d   = pll_div_q;
    pll_freq_d  = pll_freq_q;
    dco_d       = dco_q;
    lock_lost_d = 1'b0;
    expire      = 1'b0;

    unique case (state_q)
      StIdle, StFail: ;
      StHoldRst: begin
        if (timer_q == HoldLast) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StWaitLock: begin
        timer_d = timer_inc;
        if (timer_q == TimeoutLast) begin
          expire = 1'b1;
        end else if (pll_lock_detect) begin
          state_d  = StQualify;
          stable_d = '0;
        end
      end
      StQualify: begin
        timer_d = timer_inc;
        // Timeout outranks a qualification completing on the same cycle.
        if (timer_q == TimeoutLast) begin
          expire = 1'b1;
        end else if (!pll_lock_detect) begin
          state_d  = StWaitLock;
          stable_d = '0;
        end else if (stable_q == StableLast) begin
          state_d = StLocked;
          dco_d   = pll_dco_word;
        end else begin
          stable_d = stable_inc;
        end
      end
      StLocked: begin
        // Warm relock: keep the PLL running and restart from the captured word.
        if (!pll_lock_detect) begin
          state_d     = StWaitLock;
          timer_d     = '0;
          pll_freq_d  = dco_q;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (expire) begin
      if (retry_q == RetryMax) begin
        state_d = StFail;
      end else begin
        state_d    = StHoldRst;
        timer_d    = '0;
        retry_d    = retry_q + 3'd1;
        pll_freq_d = cfg_freq_q;
      end
    end

    if (xfer) begin
      state_d     = StHoldRst;
      timer_d     = '0;
      stable_d    = '0;
      retry_d     = '0;
      pll_div_d   = cfg_div_val;
      pll_freq_d  = cfg_initial_freq;
      cfg_freq_d  = cfg_initial_freq;
      lock_lost_d = 1'b0;
    end

    cfg_ready_d = (state_d == StIdle) || (state_d == StLocked) || (state_d == StFail);
    busy_d      = (state_d == StHoldRst) || (state_d == StWaitLock) || (state_d == StQualify);
    pll_rst_n_d = (state_d == StWaitLock) || (state_d == StQualify) || (state_d == StLocked);
    locked_d    = (state_d == StLocked);
    error_d     = (state_d == StFail);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      cfg_freq_q  <= '0;
      pll_div_q   <= '0;
      pll_freq_q  <= '0;
      dco_q       <= '0;
      lock_lost_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      pll_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      cfg_freq_q  <= cfg_freq_d;
      pll_div_q   <= pll_div_d;
      pll_freq_q  <= pll_freq_d;
      dco_q       <= dco_d;
      lock_lost_q <= lock_lost_d;
      cfg_ready_q <= cfg_ready_d;
      pll_rst_n_q <= pll_rst_n_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign cfg_ready        = cfg_ready_q;
  assign pll_rst_n        = pll_rst_n_q;
  assign pll_div_val      = pll_div_q;
  assign pll_initial_freq = pll_freq_q;
  assign locked           = locked_q;
  assign busy             = busy_q;
  assign error            = error_q;
  assign lock_lost        = lock_lost_q;
  assign retry_count      = retry_q;
  assign locked_dco_word  = dco_q;

endmodule
